// File: rtl/otter_retire_buffer_if.sv
// Bundle of issue, completion and register-file write signals around the
// OTTER retirement buffer. The master drives issue/completion and the slave is the buffer.
interface otter_retire_buffer_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
);
  logic             flush;
  logic             alloc_valid_1;
  logic             alloc_valid_2;
  logic [4:0]       alloc_rd_1;
  logic [4:0]       alloc_rd_2;
  logic             alloc_wen_1;
  logic             alloc_wen_2;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag_1;
  logic [TAG_W-1:0] alloc_tag_2;
  logic             cmp_valid_1;
  logic             cmp_valid_2;
  logic [TAG_W-1:0] cmp_tag_1;
  logic [TAG_W-1:0] cmp_tag_2;
  logic [31:0]      cmp_data_1;
  logic [31:0]      cmp_data_2;
  logic             RegWrite;
  logic [4:0]       WriteReg;
  logic [31:0]      WriteData;
  logic             RegWrite_2;
  logic [4:0]       WriteReg_2;
  logic [31:0]      WriteData_2;
  logic [TAG_W:0]   count;

  modport master (
    output flush, alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
           alloc_wen_1, alloc_wen_2, cmp_valid_1, cmp_valid_2, cmp_tag_1,
           cmp_tag_2, cmp_data_1, cmp_data_2,
    input  alloc_ready, alloc_tag_1, alloc_tag_2, RegWrite, WriteReg,
           WriteData, RegWrite_2, WriteReg_2, WriteData_2, count
  );

  modport slave (
    input  flush, alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
           alloc_wen_1, alloc_wen_2, cmp_valid_1, cmp_valid_2, cmp_tag_1,
           cmp_tag_2, cmp_data_1, cmp_data_2,
    output alloc_ready, alloc_tag_1, alloc_tag_2, RegWrite, WriteReg,
           WriteData, RegWrite_2, WriteReg_2, WriteData_2, count
  );
endinterface

// File: rtl/otter_retire_buffer.sv
// In-order retirement buffer: dual allocate, out-of-order completion and up to
// two in-order retirements per cycle onto the dual-port register file.
module otter_retire_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input logic              clock,
  input logic              rst_n,
  otter_retire_buffer_if.slave bus
);
  localparam int CW = TAG_W + 1;

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, wen_q, wen_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, head_nx, tail_nx;
  logic [CW-1:0]    count_q, count_d;
  logic             reg_write_q, reg_write_d, reg_write_2_q, reg_write_2_d;
  logic [4:0]       write_reg_q, write_reg_d, write_reg_2_q, write_reg_2_d;
  logic [31:0]      write_data_q, write_data_d, write_data_2_q, write_data_2_d;
  logic             alloc_ready, do_alloc_1, do_alloc_2, ret_1, ret_2;
  logic [1:0]       n_alloc, n_ret;

  assign head_nx     = head_q + TAG_W'(1);
  assign tail_nx     = tail_q + TAG_W'(1);
  assign alloc_ready = (count_q <= CW'(DEPTH - 2));

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag_1 = tail_q;
  assign bus.alloc_tag_2 = tail_nx;
  assign bus.count       = count_q;
  assign bus.RegWrite    = reg_write_q;
  assign bus.WriteReg    = write_reg_q;
  assign bus.WriteData   = write_data_q;
  assign bus.RegWrite_2  = reg_write_2_q;
  assign bus.WriteReg_2  = write_reg_2_q;
  assign bus.WriteData_2 = write_data_2_q;

  // Retirement looks only at registered done bits, never at this cycle's completions.
  always_comb begin
    ret_1      = valid_q[head_q] & done_q[head_q];
    ret_2      = ret_1 & valid_q[head_nx] & done_q[head_nx];
    do_alloc_1 = bus.alloc_valid_1 & alloc_ready;
    do_alloc_2 = do_alloc_1 & bus.alloc_valid_2;
    n_ret      = {1'b0, ret_1} + {1'b0, ret_2};
    n_alloc    = {1'b0, do_alloc_1} + {1'b0, do_alloc_2};
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    wen_d   = wen_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (bus.cmp_valid_1 && valid_q[bus.cmp_tag_1]) begin
        done_d[bus.cmp_tag_1] = 1'b1;
        data_d[bus.cmp_tag_1] = bus.cmp_data_1;
      end
      if (bus.cmp_valid_2 && valid_q[bus.cmp_tag_2]) begin
        done_d[bus.cmp_tag_2] = 1'b1;
        data_d[bus.cmp_tag_2] = bus.cmp_data_2;
      end
      if (ret_1) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
      end
      if (ret_2) begin
        valid_d[head_nx] = 1'b0;
        done_d[head_nx]  = 1'b0;
      end
      // Allocated slots are always free, so they never collide with retirees.
      if (do_alloc_1) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        wen_d[tail_q]   = bus.alloc_wen_1;
        rd_d[tail_q]    = bus.alloc_rd_1;
      end
      if (do_alloc_2) begin
        valid_d[tail_nx] = 1'b1;
        done_d[tail_nx]  = 1'b0;
        wen_d[tail_nx]   = bus.alloc_wen_2;
        rd_d[tail_nx]    = bus.alloc_rd_2;
      end
      head_d  = head_q + TAG_W'(n_ret);
      tail_d  = tail_q + TAG_W'(n_alloc);
      count_d = count_q + CW'(n_alloc) - CW'(n_ret);
    end
  end

  always_comb begin
    reg_write_d    = 1'b0;
    reg_write_2_d  = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    write_reg_2_d  = write_reg_2_q;
    write_data_2_d = write_data_2_q;
    if (!bus.flush && ret_1) begin
      write_reg_d  = rd_q[head_q];
      write_data_d = data_q[head_q];
      reg_write_d  = wen_q[head_q] && (rd_q[head_q] != 5'd0);
    end
    if (!bus.flush && ret_2) begin
      write_reg_2_d  = rd_q[head_nx];
      write_data_2_d = data_q[head_nx];
      reg_write_2_d  = wen_q[head_nx] && (rd_q[head_nx] != 5'd0);
      // Same destination on both ports: only the younger value reaches the file.
      if (reg_write_d && reg_write_2_d && (rd_q[head_q] == rd_q[head_nx]))
        reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      done_q         <= '0;
      wen_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      reg_write_q    <= 1'b0;
      reg_write_2_q  <= 1'b0;
      write_reg_q    <= '0;
      write_reg_2_q  <= '0;
      write_data_q   <= '0;
      write_data_2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      wen_q          <= wen_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      reg_write_q    <= reg_write_d;
      reg_write_2_q  <= reg_write_2_d;
      write_reg_q    <= write_reg_d;
      write_reg_2_q  <= write_reg_2_d;
      write_data_q   <= write_data_d;
      write_data_2_q <= write_data_2_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end
endmodule

// File: tb/tb_otter_retire_buffer.sv
// Self-checking bench for otter_retire_buffer: a program-order queue model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_otter_retire_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  otter_retire_buffer_if #(.DEPTH(DEPTH)) bus ();

  otter_retire_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic        wen;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        rob[$];
  ent_t        new_ent;
  int          m_tail = 0;
  int          n_before, n_ret;
  logic        m_rw = 1'b0, m_rw2 = 1'b0;
  logic [4:0]  m_wr = '0, m_wr2 = '0;
  logic [31:0] m_wd = '0, m_wd2 = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    bus.flush         = 1'b0;
    bus.alloc_valid_1 = 1'b0;
    bus.alloc_valid_2 = 1'b0;
    bus.alloc_rd_1    = '0;
    bus.alloc_rd_2    = '0;
    bus.alloc_wen_1   = 1'b0;
    bus.alloc_wen_2   = 1'b0;
    bus.cmp_valid_1   = 1'b0;
    bus.cmp_valid_2   = 1'b0;
    bus.cmp_tag_1     = '0;
    bus.cmp_tag_2     = '0;
    bus.cmp_data_1    = '0;
    bus.cmp_data_2    = '0;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clock);
    clearInputs();
  endtask

  task automatic allocPair(input logic [4:0] rd1, input logic w1,
                           input logic [4:0] rd2, input logic w2, input logic two);
    bus.alloc_valid_1 = 1'b1;
    bus.alloc_rd_1    = rd1;
    bus.alloc_wen_1   = w1;
    bus.alloc_valid_2 = two;
    bus.alloc_rd_2    = rd2;
    bus.alloc_wen_2   = w2;
  endtask

  task automatic complete1(input int tag, input logic [31:0] data);
    bus.cmp_valid_1 = 1'b1;
    bus.cmp_tag_1   = TAG_W'(tag);
    bus.cmp_data_1  = data;
  endtask

  task automatic complete2(input int tag, input logic [31:0] data);
    bus.cmp_valid_2 = 1'b1;
    bus.cmp_tag_2   = TAG_W'(tag);
    bus.cmp_data_2  = data;
  endtask

  // Program-order model: oldest entry at the front of the queue.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rob.delete();
      m_tail = 0;
      m_rw = 1'b0; m_rw2 = 1'b0;
      m_wr = '0;   m_wr2 = '0;
      m_wd = '0;   m_wd2 = '0;
    end else if (bus.flush) begin
      rob.delete();
      m_tail = 0;
      m_rw = 1'b0; m_rw2 = 1'b0;
    end else begin
      n_before = rob.size();
      n_ret = 0;
      if (n_before > 0 && rob[0].done) n_ret = (n_before > 1 && rob[1].done) ? 2 : 1;
      m_rw = 1'b0; m_rw2 = 1'b0;
      if (n_ret >= 1) begin
        m_wr = rob[0].rd; m_wd = rob[0].data;
        m_rw = rob[0].wen && (rob[0].rd != 0);
      end
      if (n_ret == 2) begin
        m_wr2 = rob[1].rd; m_wd2 = rob[1].data;
        m_rw2 = rob[1].wen && (rob[1].rd != 0);
        if (m_rw && m_rw2 && m_wr == m_wr2) m_rw = 1'b0;
      end
      foreach (rob[i]) begin
        if (bus.cmp_valid_1 && rob[i].tag == int'(bus.cmp_tag_1)) begin
          rob[i].done = 1'b1; rob[i].data = bus.cmp_data_1;
        end
        if (bus.cmp_valid_2 && rob[i].tag == int'(bus.cmp_tag_2)) begin
          rob[i].done = 1'b1; rob[i].data = bus.cmp_data_2;
        end
      end
      repeat (n_ret) void'(rob.pop_front());
      if (bus.alloc_valid_1 && n_before <= DEPTH - 2) begin
        new_ent.tag = m_tail; new_ent.rd = bus.alloc_rd_1; new_ent.wen = bus.alloc_wen_1;
        new_ent.done = 1'b0; new_ent.data = '0;
        rob.push_back(new_ent);
        m_tail = (m_tail + 1) % DEPTH;
        if (bus.alloc_valid_2) begin
          new_ent.tag = m_tail; new_ent.rd = bus.alloc_rd_2; new_ent.wen = bus.alloc_wen_2;
          rob.push_back(new_ent);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (rst_n) begin
      checkOutput("count",       32'(bus.count),       32'(rob.size()));
      checkOutput("alloc_ready", 32'(bus.alloc_ready), 32'(rob.size() <= DEPTH - 2));
      checkOutput("alloc_tag_1", 32'(bus.alloc_tag_1), 32'(m_tail));
      checkOutput("alloc_tag_2", 32'(bus.alloc_tag_2), 32'((m_tail + 1) % DEPTH));
      checkOutput("RegWrite",    32'(bus.RegWrite),    32'(m_rw));
      checkOutput("WriteReg",    32'(bus.WriteReg),    32'(m_wr));
      checkOutput("WriteData",   bus.WriteData,        m_wd);
      checkOutput("RegWrite_2",  32'(bus.RegWrite_2),  32'(m_rw2));
      checkOutput("WriteReg_2",  32'(bus.WriteReg_2),  32'(m_wr2));
      checkOutput("WriteData_2", bus.WriteData_2,      m_wd2);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    repeat (2) @(negedge clock);
    checkOutput("rst count",  32'(bus.count), 0);
    checkOutput("rst tag1",   32'(bus.alloc_tag_1), 0);
    checkOutput("rst tag2",   32'(bus.alloc_tag_2), 1);
    checkOutput("rst ready",  32'(bus.alloc_ready), 1);
    checkOutput("rst rw",     32'(bus.RegWrite), 0);
    rst_n = 1'b1;
    applyStimulus(1);

    // Fill to full, then a rejected allocation attempt.
    for (int i = 0; i < 4; i++) begin
      allocPair(5'(10 + 2 * i), 1'b1, 5'(11 + 2 * i), 1'b1, 1'b1);
      applyStimulus(1);
    end
    checkOutput("full count", 32'(bus.count), 8);
    checkOutput("full ready", 32'(bus.alloc_ready), 0);
    checkOutput("full tag1",  32'(bus.alloc_tag_1), 0);
    allocPair(5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("full ignore count", 32'(bus.count), 8);
    checkOutput("full ignore tag1",  32'(bus.alloc_tag_1), 0);

    // Drain with completions in order, retirement overlapping.
    for (int j = 0; j < 4; j++) begin
      complete1(2 * j, 32'h100 + 32'(2 * j));
      complete2(2 * j + 1, 32'h101 + 32'(2 * j));
      applyStimulus(1);
    end
    applyStimulus(1);
    checkOutput("drain wr",   32'(bus.WriteReg), 16);
    checkOutput("drain wr2",  32'(bus.WriteReg_2), 17);
    checkOutput("drain wd2",  bus.WriteData_2, 32'h107);
    checkOutput("drain count", 32'(bus.count), 0);
    checkOutput("wrap tag1",  32'(bus.alloc_tag_1), 0);
    checkOutput("wrap tag2",  32'(bus.alloc_tag_2), 1);

    // Out-of-order completion, in-order retirement.
    allocPair(5'd5, 1'b1, 5'd6, 1'b1, 1'b1);
    applyStimulus(1);
    complete1(1, 32'h22);
    applyStimulus(1);
    complete2(0, 32'h11);
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("ooo rw",  32'(bus.RegWrite), 1);
    checkOutput("ooo wr",  32'(bus.WriteReg), 5);
    checkOutput("ooo wd",  bus.WriteData, 32'h11);
    checkOutput("ooo rw2", 32'(bus.RegWrite_2), 1);
    checkOutput("ooo wr2", 32'(bus.WriteReg_2), 6);
    checkOutput("ooo wd2", bus.WriteData_2, 32'h22);
    applyStimulus(1);
    checkOutput("ooo one-cycle rw",  32'(bus.RegWrite), 0);
    checkOutput("ooo one-cycle rw2", 32'(bus.RegWrite_2), 0);

    // Same destination on both retirees.
    allocPair(5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
    applyStimulus(1);
    complete1(2, 32'hA);
    complete2(3, 32'hB);
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("same rw",  32'(bus.RegWrite), 0);
    checkOutput("same rw2", 32'(bus.RegWrite_2), 1);
    checkOutput("same wr2", 32'(bus.WriteReg_2), 7);
    checkOutput("same wd2", bus.WriteData_2, 32'hB);

    // Silent retirement: rd=0 and wen=0.
    allocPair(5'd0, 1'b1, 5'd9, 1'b0, 1'b1);
    applyStimulus(1);
    complete1(4, 32'h44);
    complete2(5, 32'h55);
    applyStimulus(1);
    checkOutput("silent pre count", 32'(bus.count), 2);
    applyStimulus(1);
    checkOutput("silent rw",    32'(bus.RegWrite), 0);
    checkOutput("silent rw2",   32'(bus.RegWrite_2), 0);
    checkOutput("silent count", 32'(bus.count), 0);

    // Flush with six live entries and a completion aimed at the head.
    for (int i = 0; i < 3; i++) begin
      allocPair(5'(20 + i), 1'b1, 5'(24 + i), 1'b1, 1'b1);
      applyStimulus(1);
    end
    checkOutput("pre-flush count", 32'(bus.count), 6);
    bus.flush = 1'b1;
    complete1(6, 32'h66);
    applyStimulus(1);
    checkOutput("flush count", 32'(bus.count), 0);
    checkOutput("flush rw",    32'(bus.RegWrite), 0);
    checkOutput("flush tag1",  32'(bus.alloc_tag_1), 0);
    applyStimulus(1);
    checkOutput("flush after rw", 32'(bus.RegWrite), 0);

    // Asynchronous reset with three live entries.
    allocPair(5'd3, 1'b1, 5'd4, 1'b1, 1'b1);
    applyStimulus(1);
    allocPair(5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    complete1(0, 32'h33);
    applyStimulus(1);
    checkOutput("pre-reset count", 32'(bus.count), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset count", 32'(bus.count), 0);
    checkOutput("areset tag1",  32'(bus.alloc_tag_1), 0);
    checkOutput("areset tag2",  32'(bus.alloc_tag_2), 1);
    checkOutput("areset ready", 32'(bus.alloc_ready), 1);
    checkOutput("areset wd",    bus.WriteData, 0);
    checkOutput("areset wr2",   32'(bus.WriteReg_2), 0);
    @(negedge clock);
    rst_n = 1'b1;
    allocPair(5'd12, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("post-reset count", 32'(bus.count), 1);
    complete1(0, 32'hC0DE);
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("post-reset rw",  32'(bus.RegWrite), 1);
    checkOutput("post-reset wr",  32'(bus.WriteReg), 12);
    checkOutput("post-reset wd",  bus.WriteData, 32'hC0DE);
    checkOutput("post-reset rw2", 32'(bus.RegWrite_2), 0);

    // Sustained dual allocate / dual complete / dual retire.
    for (int k = 0; k < 10; k++) begin
      allocPair(5'(k + 1), 1'b1, 5'(k + 17), 1'b1, 1'b1);
      if (k > 0) begin
        complete1((1 + 2 * k + 6) % DEPTH, 32'h1000 + 32'(k));
        complete2((1 + 2 * k + 7) % DEPTH, 32'h2000 + 32'(k));
      end
      applyStimulus(1);
    end
    complete1((1 + 20 + 6) % DEPTH, 32'h1000 + 32'd10);
    complete2((1 + 20 + 7) % DEPTH, 32'h2000 + 32'd10);
    applyStimulus(1);
    applyStimulus(3);
    checkOutput("sustain count", 32'(bus.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/otter_retire_buffer.md
# otter_retire_buffer

In-order retirement buffer for the dual-issue OTTER core, sitting directly upstream of the dual-write-port register file. Two issue slots allocate entries in program order. Results return out of order from the two execution pipes. Up to two oldest completed entries retire per cycle, in order, onto the register file's two write ports: port 1 carries the older entry, port 2 the younger.

## Interface
- DEPTH, 8, number of entries; power of two, at least 4
- TAG_W, $clog2(DEPTH), entry tag width

- clock  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all entries
- alloc_valid_1  in  1  allocate the older instruction of the issue pair
- alloc_valid_2  in  1  allocate the younger instruction; legal only with alloc_valid_1
- alloc_rd_1, alloc_rd_2  in  5  destination registers
- alloc_wen_1, alloc_wen_2  in  1  instruction writes its rd
- alloc_ready  out  1  two or more free entries (count <= DEPTH-2)
- alloc_tag_1, alloc_tag_2  out  TAG_W  tags assigned this cycle: tail and tail+1 (mod DEPTH); combinational from registered tail
- cmp_valid_1, cmp_valid_2  in  1  result return from pipe 1 / pipe 2
- cmp_tag_1, cmp_tag_2  in  TAG_W  tag of the completing entry
- cmp_data_1, cmp_data_2  in  32  result data
- RegWrite, WriteReg, WriteData  out  1/5/32  register-file port 1 (older retiree), registered
- RegWrite_2, WriteReg_2, WriteData_2  out  1/5/32  register-file port 2 (younger retiree), registered
- count  out  TAG_W+1  occupied entries, registered

## Operation
- Each entry holds: valid, done, rd, wen, data[31:0]. Entries form a circular buffer with head and tail pointers, both wrapping mod DEPTH.
- **Allocate** on a rising edge with alloc_valid_1 && alloc_ready:
  - one entry, or two if alloc_valid_2 is also high;
  - fields are written, done=0, tail advances by 1 or 2.
  - alloc_valid_2 without alloc_valid_1 is ignored.
  - Allocation while !alloc_ready is ignored: no state change, no error.
- **Complete** when cmp_valid_x is high:
  - the entry at cmp_tag_x gets done=1 and data=cmp_data_x.
  - A tag that is not valid is ignored.
  - Both pipes returning the same tag in one cycle is illegal; the bench must not drive it.
  - Completing a tag in the same cycle it is allocated is illegal.
- **Retire**, decided from registered state only:
  - If head is valid and done, retire head.
  - If head+1 is also valid and done, retire it as well. There is never a skip past an incomplete head.
  - Head and count are updated by the number retired.
- **Write-port mapping**, registered at the retire edge:
  - RegWrite = wen && rd != 0; likewise RegWrite_2 for the second retiree.
  - Entries with wen=0 retire silently.
  - If both retirees write the same nonzero rd, RegWrite is forced to 0 and only port 2 writes, so the younger value wins.
  - With a single retiree, port 2 is idle: RegWrite_2=0.
  - WriteReg and WriteData always show the retiring entry's fields, or hold their last value when idle.
- **Simultaneous events** in one cycle are all legal:
  - alloc, complete and retire together;
  - count_next = count + allocated − retired;
  - alloc_ready uses the current count and does not credit same-cycle retirement.
- **Full** (count==DEPTH): alloc_ready=0, retirement continues. **Empty**: no retirement, write ports idle.
- **Flush** has highest priority:
  - head=tail=count=0, all valid/done bits cleared;
  - RegWrite=RegWrite_2=0 on the next cycle;
  - any alloc, complete or retire presented in the flush cycle is discarded.
- **Reset** (async, rst_n=0): same state as flush. All outputs are 0: RegWrite, RegWrite_2, WriteReg, WriteReg_2, WriteData, WriteData_2, count, and alloc_tag_1=0, alloc_tag_2=1, alloc_ready=1. Reset mid-operation drops all in-flight entries.

## Timing
- Allocation at edge E0 → tag usable for completion from cycle E0+1.
- Completion sampled at edge E1 → done visible after E1 → retire decision in the following cycle → head advances and write-port outputs register at E2.
- Write ports are valid for exactly one cycle after E2. The register file samples them at the falling edge inside that cycle.
- Minimum allocate-to-write: 3 rising edges (E0 alloc, E1 complete, E2 retire).
- Throughput: 2 allocations and 2 retirements per cycle sustained.
- alloc_tag_x and alloc_ready are combinational from registered pointers/count, with no input-to-output path.

## Test plan
- **Reset:** drive rst_n=0 mid-cycle with 3 entries live → outputs zero immediately, count=0, alloc_tag_1=0, alloc_tag_2=1; after release, a fresh alloc gets tag 0.
- **Out-of-order retire:** alloc pair rd=5, rd=6 (tags 0,1). Complete tag 1 with 0x22, then one cycle later tag 0 with 0x11 → a single cycle with RegWrite=1/WriteReg=5/WriteData=0x11 and RegWrite_2=1/WriteReg_2=6/WriteData_2=0x22.
- **Same-rd conflict:** alloc pair both rd=7; complete both together with 0xA and 0xB → RegWrite=0, RegWrite_2=1, WriteData_2=0xB.
- **Silent retire:** rd=0 or wen=0 entries → RegWrite=0 but count decrements.
- **Full / wrap:** DEPTH=8; allocate 4 pairs → count=8, alloc_ready=0; an alloc attempt is ignored with tail unchanged. Complete and retire all, then allocate again → tags 0,1 after head/tail wrap.
- **Flush:** flush with 6 entries live while cmp_valid_1 targets the head → next cycle count=0, no RegWrite, and the completion is lost.
